vga_frame_fetch: RTL

//  Display-side consumer of the frame buffer the graphics controller writes into SRAM.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_timing_gen.sv | 57 +++++
 rtl/vga_frame_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA frame fetch block: 640x480@60 timing
// constants, derived line/frame totals, the frame buffer base address, the
// pixel colour struct and the fetch FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    localparam int H_SYNC_FIRST = H_ACTIVE + H_FP;               // 656
    localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;     // 751
    localparam int V_SYNC_FIRST = V_ACTIVE + V_FP;               // 490
    localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;     // 491

    // Two pixels per 16-bit SRAM word.
    localparam int WORDS_PER_LINE = H_ACTIVE / 2;                // 320

    localparam logic [17:0] FB_BASE = 18'h00000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Word offset of a frame buffer row: row*320 built from shifts (256+64).
    function automatic logic [18:0] row_offset(input logic [9:0] row);
        return ({9'd0, row} << 8) + ({9'd0, row} << 6);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running horizontal/vertical counters for 640x480@60 and the raw
// (undelayed) sync, active-area and frame-start decodes of those counters.
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   hcount [9:0]      0..799
//   vcount [9:0]      0..524
//   hsync_l, vsync_l  active-low syncs at counter time
//   active            hcount<640 && vcount<480
//   frame_start       high while the counters read (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_l,
    output logic       vsync_l,
    output logic       active,
    output logic       frame_start
);

    logic [9:0] hcount_r;
    logic [9:0] vcount_r;

    // Pixel and line counters; vcount advances when hcount wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (hcount_r == 10'(H_TOTAL - 1)) begin
            hcount_r <= 10'd0;
            if (vcount_r == 10'(V_TOTAL - 1)) begin
                vcount_r <= 10'd0;
            end else begin
                vcount_r <= vcount_r + 10'd1;
            end
        end else begin
            hcount_r <= hcount_r + 10'd1;
            vcount_r <= vcount_r;
        end
    end

    // Raw decodes of the current counter values.
    always_comb begin
        hcount      = hcount_r;
        vcount      = vcount_r;
        hsync_l     = !((hcount_r >= 10'(H_SYNC_FIRST)) && (hcount_r <= 10'(H_SYNC_LAST)));
        vsync_l     = !((vcount_r >= 10'(V_SYNC_FIRST)) && (vcount_r <= 10'(V_SYNC_LAST)));
        active      = (hcount_r < 10'(H_ACTIVE)) && (vcount_r < 10'(V_ACTIVE));
        frame_start = (hcount_r == 10'd0) && (vcount_r == 10'd0);
    end

endmodule

// File: rtl/vga_frame_fetch.sv
// -----------------------------------------------------------------------------
// vga_frame_fetch
// Display-side frame buffer reader. Generates VGA timing, fetches two 8-bit
// pixel indices per SRAM word on even active pixels, looks them up in the
// colour palette and drives RGB with syncs delayed to stay aligned.
// Ports:
//   Clk, Reset_H               pixel clock, asynchronous active-high reset
//   Enable_H                   display enable, taken at frame start only
//   HScrollValue, VScrollValue scroll in pixels (bit 0 ignored) / lines
//   Sram_DataIn [15:0]         read data one cycle after the address
//   Sram_AddressOut [17:0]     word address (0 when not fetching)
//   Sram_RW_Out                always 1 (read)
//   Sram_UDS_Out_L/LDS_Out_L   low on fetch cycles
//   Display_SramBusy_H         high on fetch cycles
//   ColourPalletteAddr [7:0]   palette index
//   ColourPalletteData [31:0]  palette entry one cycle after the index
//   HSync_L, VSync_L, Blank_L  timing outputs aligned with RGB
//   Red, Green, Blue [7:0]     pixel colour, 0 when blanked or idle
//   FrameStart_H               one-cycle pulse aligned with pixel (0,0)
// -----------------------------------------------------------------------------
module vga_frame_fetch
    import vga_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_H,
    input  logic        Enable_H,
    input  logic [9:0]  HScrollValue,
    input  logic [9:0]  VScrollValue,
    input  logic [15:0] Sram_DataIn,
    output logic [17:0] Sram_AddressOut,
    output logic        Sram_RW_Out,
    output logic        Sram_UDS_Out_L,
    output logic        Sram_LDS_Out_L,
    output logic        Display_SramBusy_H,
    output logic [7:0]  ColourPalletteAddr,
    input  logic [31:0] ColourPalletteData,
    output logic        HSync_L,
    output logic        VSync_L,
    output logic        Blank_L,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        FrameStart_H
);

    // {hsync_l, vsync_l, active, frame_start} value held in reset.
    localparam logic [3:0] SYNC_RESET = 4'b1100;

    logic [9:0]  hcount_s;
    logic [9:0]  vcount_s;
    logic        hsync_raw_s;
    logic        vsync_raw_s;
    logic        active_s;
    logic        frame_start_s;

    fsm_state_t  state_r;
    logic [8:0]  hs_half_r;
    logic [9:0]  y_r;
    logic [18:0] line_base_r;

    logic        run_s;
    logic [8:0]  hs_half_s;
    logic [9:0]  vs_s;
    logic [18:0] line_base_s;
    logic [9:0]  word_sum_s;
    logic [9:0]  word_idx_s;
    logic [18:0] addr_s;
    logic        fetch_s;

    logic        even_r;
    logic        odd_r;
    logic [7:0]  odd_px_r;
    logic        pal_valid_r;
    rgb_t        rgb_r;
    logic [3:0]  sync_d1_r;
    logic [3:0]  sync_d2_r;
    logic [3:0]  sync_d3_r;

    vga_timing_gen u_timing (
        .clk         (Clk),
        .rst         (Reset_H),
        .hcount      (hcount_s),
        .vcount      (vcount_s),
        .hsync_l     (hsync_raw_s),
        .vsync_l     (vsync_raw_s),
        .active      (active_s),
        .frame_start (frame_start_s)
    );

    // Fetch decision and word address for the current counter position.
    // During the (0,0) cycle the enable and scroll inputs are used directly so
    // that pixel (0,0) of a newly enabled frame is fetched with the new values.
    always_comb begin
        if (frame_start_s) begin
            run_s       = Enable_H;
            hs_half_s   = (HScrollValue >= 10'(H_ACTIVE)) ? 9'd0 : 9'(HScrollValue >> 1);
            vs_s        = (VScrollValue >= 10'(V_ACTIVE)) ? 10'd0 : VScrollValue;
            line_base_s = {1'b0, FB_BASE} + row_offset(vs_s);
        end else begin
            run_s       = (state_r == RUN);
            hs_half_s   = hs_half_r;
            vs_s        = y_r;
            line_base_s = line_base_r;
        end
        // hs/2 + hcount/2 stays below 2*320, so one conditional subtract wraps it.
        word_sum_s = {1'b0, hs_half_s} + {1'b0, hcount_s[9:1]};
        if (word_sum_s >= 10'(WORDS_PER_LINE)) begin
            word_idx_s = word_sum_s - 10'(WORDS_PER_LINE);
        end else begin
            word_idx_s = word_sum_s;
        end
        addr_s  = line_base_s + {9'd0, word_idx_s};
        // Reset gating keeps the bus released while the counters sit at (0,0).
        fetch_s = !Reset_H && run_s && active_s && !hcount_s[0];
    end

    // Frame control FSM: mode and scroll latched at frame start, line base
    // advanced by one row at the end of every line.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            state_r     <= IDLE;
            hs_half_r   <= 9'd0;
            y_r         <= 10'd0;
            line_base_r <= {1'b0, FB_BASE};
        end else if (frame_start_s) begin
            state_r     <= run_s ? RUN : IDLE;
            hs_half_r   <= hs_half_s;
            y_r         <= vs_s;
            line_base_r <= line_base_s;
        end else if (hcount_s == 10'(H_TOTAL - 1)) begin
            state_r   <= state_r;
            hs_half_r <= hs_half_r;
            if (y_r == 10'(V_ACTIVE - 1)) begin
                y_r         <= 10'd0;
                line_base_r <= {1'b0, FB_BASE};
            end else begin
                y_r         <= y_r + 10'd1;
                line_base_r <= line_base_r + 19'(WORDS_PER_LINE);
            end
        end else begin
            state_r     <= state_r;
            hs_half_r   <= hs_half_r;
            y_r         <= y_r;
            line_base_r <= line_base_r;
        end
    end

    // Data pipeline: SRAM word, palette lookup, RGB register.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            even_r      <= 1'b0;
            odd_r       <= 1'b0;
            odd_px_r    <= 8'd0;
            pal_valid_r <= 1'b0;
            rgb_r       <= '0;
        end else begin
            even_r      <= fetch_s;
            odd_r       <= even_r;
            odd_px_r    <= even_r ? Sram_DataIn[7:0] : odd_px_r;
            pal_valid_r <= even_r || odd_r;
            rgb_r       <= pal_valid_r ? rgb_t'(24'(ColourPalletteData)) : '0;
        end
    end

    // Three-stage delay so the timing outputs line up with RGB.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            sync_d1_r <= SYNC_RESET;
            sync_d2_r <= SYNC_RESET;
            sync_d3_r <= SYNC_RESET;
        end else begin
            sync_d1_r <= {hsync_raw_s, vsync_raw_s, active_s, frame_start_s};
            sync_d2_r <= sync_d1_r;
            sync_d3_r <= sync_d2_r;
        end
    end

    // Output drive: even pixel index straight from the bus, odd from the held byte.
    always_comb begin
        if (even_r) begin
            ColourPalletteAddr = Sram_DataIn[15:8];
        end else if (odd_r) begin
            ColourPalletteAddr = odd_px_r;
        end else begin
            ColourPalletteAddr = 8'd0;
        end
        Sram_AddressOut    = fetch_s ? 18'(addr_s) : 18'd0;
        Sram_RW_Out        = 1'b1;
        Sram_UDS_Out_L     = !fetch_s;
        Sram_LDS_Out_L     = !fetch_s;
        Display_SramBusy_H = fetch_s;
        HSync_L            = sync_d3_r[3];
        VSync_L            = sync_d3_r[2];
        Blank_L            = sync_d3_r[1];
        FrameStart_H       = sync_d3_r[0];
        Red                = rgb_r.r;
        Green              = rgb_r.g;
        Blue               = rgb_r.b;
    end

endmodule
